frb_pulse_injector: RTL and testbench

FRB_PULSE_INJECTOR -- requirements
Module: frb_pulse_injector

---
 rtl/frb_pulse_injector.sv | 150 +++++++++++++++
 tb/tb_frb_pulse_injector.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/frb_pulse_injector.sv
// Injects one dispersed pulse into a channel-serial spectrum stream using a per-channel delay table.
// Optional INJECT_SATURATE_EN: saturate the in-pulse addition instead of wrapping.
module frb_pulse_injector #(
  parameter int unsigned N_CHANNELS  = 64,
  parameter int unsigned DIN_WIDTH   = 32,
  parameter int unsigned DELAY_WIDTH = 10,
  parameter int unsigned PULSE_LEN   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIN_WIDTH-1:0]          din,
  input  logic                          din_valid,
  input  logic                          trigger,
  input  logic [DIN_WIDTH-1:0]          amplitude,
  input  logic                          dly_we,
  input  logic [$clog2(N_CHANNELS)-1:0] dly_addr,
  input  logic [DELAY_WIDTH-1:0]        dly_data,
  output logic [DIN_WIDTH-1:0]          dout,
  output logic                          dout_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned CW = $clog2(N_CHANNELS);
  localparam int unsigned TW = DELAY_WIDTH + $clog2(PULSE_LEN) + 1;
  localparam logic [TW-1:0] T_LAST  = TW'((2 ** DELAY_WIDTH) + PULSE_LEN - 2);
  localparam logic [CW-1:0] CH_LAST = CW'(N_CHANNELS - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StInject} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          ch_q;
  logic [DELAY_WIDTH-1:0] dly_mem [N_CHANNELS];
  logic [DELAY_WIDTH-1:0] dly_rd_q;
  logic [TW-1:0]          t_q;
  logic [DIN_WIDTH-1:0]   amp_q;

  logic                   s1_valid, s1_inj, s1_last;
  logic [DIN_WIDTH-1:0]   s1_din;
  logic [TW-1:0]          s1_t;

  logic [DIN_WIDTH-1:0]   dout_q;
  logic                   dout_valid_q, done_q;

  logic ch_first, ch_last;
  logic amp_load, start_inj, in_inj, t_step, last_sample;

  assign ch_first = (ch_q == '0);
  assign ch_last  = (ch_q == CH_LAST);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (trigger)     state_d = StArmed;
      StArmed:  if (start_inj)   state_d = StInject;
      StInject: if (last_sample) state_d = StIdle;
      default:                   state_d = StIdle;
    endcase
  end

  // FSM: decoded outputs
  always_comb begin
    busy        = (state_q != StIdle);
    amp_load    = (state_q == StIdle) && trigger;
    start_inj   = (state_q == StArmed) && din_valid && ch_first;
    in_inj      = din_valid && ((state_q == StInject) || start_inj);
    t_step      = (state_q == StInject) && din_valid && ch_last;
    last_sample = t_step && (t_q == T_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q  <= '0;
      t_q   <= '0;
      amp_q <= '0;
    end else begin
      if (din_valid) ch_q <= ch_last ? '0 : ch_q + 1'b1;
      if (start_inj)                  t_q <= '0;
      else if (t_step && !last_sample) t_q <= t_q + 1'b1;
      if (amp_load) amp_q <= amplitude;
    end
  end

  // Read-before-write: a same-cycle write to the read address returns the old delay.
  always_ff @(posedge clk) begin
    if (dly_we) dly_mem[dly_addr] <= dly_data;
    dly_rd_q <= dly_mem[ch_q];
  end

  // Stage 1 aligns each sample with its registered delay read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_inj   <= 1'b0;
      s1_last  <= 1'b0;
      s1_din   <= '0;
      s1_t     <= '0;
    end else begin
      s1_valid <= din_valid;
      s1_inj   <= in_inj;
      s1_last  <= last_sample;
      s1_din   <= din;
      s1_t     <= start_inj ? '0 : t_q;
    end
  end

  logic [TW-1:0]        dly_ext;
  logic                 hit;
  logic [DIN_WIDTH-1:0] inj_val;

`ifdef INJECT_SATURATE_EN
  logic [DIN_WIDTH:0] sum_full;
  always_comb begin
    sum_full = {1'b0, s1_din} + {1'b0, amp_q};
    inj_val  = sum_full[DIN_WIDTH] ? '1 : sum_full[DIN_WIDTH-1:0];
  end
`else
  assign inj_val = s1_din + amp_q;
`endif

  // TW is sized so delay + PULSE_LEN never overflows.
  always_comb begin
    dly_ext = {{(TW - DELAY_WIDTH){1'b0}}, dly_rd_q};
    hit     = s1_inj && (s1_t >= dly_ext) && (s1_t < dly_ext + TW'(PULSE_LEN));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      dout_q       <= hit ? inj_val : s1_din;
      dout_valid_q <= s1_valid;
      done_q       <= s1_last;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_frb_pulse_injector.sv
// Directed bench for frb_pulse_injector with N_CHANNELS=4, DELAY_WIDTH=3, PULSE_LEN=2.
module tb_frb_pulse_injector;

  localparam int unsigned NC  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned DLW = 3;
  localparam int unsigned PL  = 2;

  logic          clk;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          trigger;
  logic [DW-1:0] amplitude;
  logic          dly_we;
  logic [1:0]    dly_addr;
  logic [DLW-1:0] dly_data;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          busy;
  logic          done;

  frb_pulse_injector #(
    .N_CHANNELS (NC),
    .DIN_WIDTH  (DW),
    .DELAY_WIDTH(DLW),
    .PULSE_LEN  (PL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .trigger   (trigger),
    .amplitude (amplitude),
    .dly_we    (dly_we),
    .dly_addr  (dly_addr),
    .dly_data  (dly_data),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] out_q[$];
  int done_cnt = 0;
  int done_idx = -1;
  int done_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: collects valid samples and where done lands.
  always @(negedge clk) begin
    if (dout_valid) out_q.push_back(dout);
    if (done) begin
      done_cnt++;
      done_idx = out_q.size() - 1;
      if (!dout_valid) done_bad++;
    end
  end

  function automatic logic [31:0] get_out(input int i);
    if (i < out_q.size()) return out_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Delays {0,1,2,3}, amplitude 100, din 5: channel c is hot in spectra c and c+1 while t <= 8.
  function automatic logic [31:0] exp_pulse(input int s, input int c);
    if (s <= 8 && (s == c || s == c + 1)) return 32'd105;
    return 32'd5;
  endfunction

  task automatic clear_mon();
    out_q.delete();
    done_cnt = 0;
    done_idx = -1;
    done_bad = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b0; trigger = 1'b0; dly_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    @(negedge clk);
    din = d; din_valid = 1'b1; trigger = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0; trigger = 1'b0;
    end
  endtask

  task automatic wr_dly(input logic [1:0] a, input logic [DLW-1:0] d);
    @(negedge clk);
    dly_we = 1'b1; dly_addr = a; dly_data = d; din_valid = 1'b0;
    @(negedge clk);
    dly_we = 1'b0;
  endtask

  task automatic fire(input logic [31:0] a);
    @(negedge clk);
    trigger = 1'b1; amplitude = a; din_valid = 1'b0;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic check_pulse(input string name);
    check({name, "_count"}, out_q.size(), 40);
    for (int s = 0; s < 10; s++)
      for (int c = 0; c < 4; c++)
        check($sformatf("%s[t%0d,c%0d]", name, s, c), get_out(s * 4 + c), exp_pulse(s, c));
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_done_idx"}, done_idx, 35);
    check({name, "_done_aligned"}, done_bad, 0);
    check({name, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; trigger = 1'b0; amplitude = '0;
    dly_we = 1'b0; dly_addr = '0; dly_data = '0;
    do_reset();

    check("rst_dout", dout, 32'd0);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // Passthrough with two-cycle latency
    clear_mon();
    send(32'd10);
    send(32'd11);
    check("pt_lat1_valid", dout_valid, 1'b0);
    send(32'd12);
    check("pt_lat2_valid", dout_valid, 1'b1);
    check("pt_lat2_dout", dout, 32'd10);
    send(32'd13);
    idle(4);
    check("pt_count", out_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("pt[%0d]", i), get_out(i), 32'd10 + i);
    check("pt_busy", busy, 1'b0);

    // Continuous pulse injection
    do_reset();
    for (int c = 0; c < 4; c++) wr_dly(c[1:0], c[DLW-1:0]);
    clear_mon();
    fire(32'd100);
    check("armed_busy", busy, 1'b1);
    for (int s = 0; s < 10; s++)
      for (int c = 0; c < 4; c++) send(32'd5);
    idle(4);
    check_pulse("pulse");

    // Gapped input gives the same pattern
    clear_mon();
    fire(32'd100);
    for (int s = 0; s < 10; s++)
      for (int c = 0; c < 4; c++) begin
        send(32'd5);
        idle(1);
      end
    idle(4);
    check_pulse("gap");

    // Overflow of the in-pulse addition on channel 0 (delay 0)
    do_reset();
    clear_mon();
    fire(32'h20);
    for (int c = 0; c < 4; c++) send(32'hFFFF_FFF0);
    idle(4);
    check("ovf_count", out_q.size(), 4);
`ifdef INJECT_SATURATE_EN
    check("ovf_ch0", get_out(0), 32'hFFFF_FFFF);
`else
    check("ovf_ch0", get_out(0), 32'h0000_0010);
`endif
    for (int c = 1; c < 4; c++) check($sformatf("ovf_ch%0d", c), get_out(c), 32'hFFFF_FFF0);

    // Trigger while busy is ignored; reset mid-injection aborts without done
    do_reset();
    clear_mon();
    fire(32'd100);
    for (int s = 0; s < 3; s++)
      for (int c = 0; c < 4; c++)
        if (!(s == 2 && c >= 2)) begin
          send(32'd5);
          if (s == 0 && c == 1) begin
            trigger = 1'b1;
            amplitude = 32'd50;
          end
        end
    idle(4);
    check("abort_count", out_q.size(), 10);
    for (int i = 0; i < 10; i++)
      check($sformatf("abort[%0d]", i), get_out(i), exp_pulse(i / 4, i % 4));
    check("abort_busy_pre", busy, 1'b1);
    do_reset();
    check("abort_busy_post", busy, 1'b0);
    check("abort_done_pre", done_cnt, 0);
    clear_mon();
    for (int i = 0; i < 12; i++) send(32'd5 + i);
    idle(4);
    check("post_count", out_q.size(), 12);
    for (int i = 0; i < 12; i++) check($sformatf("post[%0d]", i), get_out(i), 32'd5 + i);
    check("post_done", done_cnt, 0);
    check("post_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
